npc_predict: RTL

NPC_PREDICT -- requirements
Module: npc_predict

---
 rtl/npc_predict.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/npc_predict.sv
// Next-PC predictor: registered fetch PC, direct-mapped BTB with 2-bit
// counters, resolution of control flow from execute, and mispredict count.
module npc_predict #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [1:0]      ex_npc_op,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispred_cnt
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    localparam logic [1:0] OpSeq    = 2'b00;
    localparam logic [1:0] OpBranch = 2'b01;
    localparam logic [1:0] OpJal    = 2'b10;
    localparam logic [1:0] OpJalr   = 2'b11;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     mispred_q;

    logic            btb_valid_q  [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0] btb_target_q [BTB_ENTRIES];
    logic [1:0]      btb_type_q   [BTB_ENTRIES];
    logic [1:0]      btb_ctr_q    [BTB_ENTRIES];

    // Fetch-side lookup
    logic [IDX-1:0]  rd_idx;
    logic            rd_hit;
    logic [XLEN-1:0] pc_plus4;

    assign rd_idx   = pc_q[IDX+1:2];
    assign rd_hit   = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[XLEN-1:IDX+2]);
    assign pc_plus4 = pc_q + XLEN'(4);

    assign pred_taken  = rd_hit && (btb_type_q[rd_idx][1] || btb_ctr_q[rd_idx][1]);
    assign pred_target = pred_taken ? btb_target_q[rd_idx] : pc_plus4;

    // Actual outcome of the resolving instruction
    logic            act_taken;
    logic [XLEN-1:0] act_next;

    // Resolve direction and next address from the op
    always_comb begin
        act_taken = 1'b0;
        act_next  = ex_pc + XLEN'(4);
        case (ex_npc_op)
            OpBranch: begin
                if (ex_taken) begin
                    act_taken = 1'b1;
                    act_next  = ex_pc + ex_imm;
                end
            end
            OpJal: begin
                act_taken = 1'b1;
                act_next  = ex_pc + ex_imm;
            end
            OpJalr: begin
                act_taken = 1'b1;
                act_next  = ex_alu_result & ~XLEN'(1);
            end
            default: ;
        endcase
    end

    assign redirect    = ex_valid &&
                         ((act_taken != ex_pred_taken) ||
                          (act_taken && (act_next != ex_pred_target)));
    assign redirect_pc = act_next;

    // Update-side lookup, served from pre-update contents
    logic [IDX-1:0]  wr_idx;
    logic [TAGW-1:0] wr_tag;
    logic            wr_hit;
    logic            btb_we;
    logic [1:0]      wr_ctr;
    logic [XLEN-1:0] wr_target;

    assign wr_idx = ex_pc[IDX+1:2];
    assign wr_tag = ex_pc[XLEN-1:IDX+2];
    assign wr_hit = btb_valid_q[wr_idx] && (btb_tag_q[wr_idx] == wr_tag);
    // Misses only allocate when taken so never-taken branches do not evict entries
    assign btb_we = ex_valid && (ex_npc_op != OpSeq) && (wr_hit || act_taken);

    // New counter and target for the written entry
    always_comb begin
        wr_ctr    = btb_ctr_q[wr_idx];
        wr_target = act_next;
        if (wr_hit) begin
            if (act_taken) begin
                if (wr_ctr != 2'b11) wr_ctr = wr_ctr + 2'b01;
            end else begin
                if (wr_ctr != 2'b00) wr_ctr = wr_ctr - 2'b01;
                wr_target = btb_target_q[wr_idx];
            end
        end else begin
            wr_ctr = (ex_npc_op == OpBranch) ? 2'b10 : 2'b11;
        end
    end

    // Next fetch PC: redirect beats stall beats prediction
    always_comb begin
        pc_d = pc_plus4;
        if (redirect)        pc_d = redirect_pc;
        else if (stall)      pc_d = pc_q;
        else if (pred_taken) pc_d = pred_target;
    end

    // Fetch PC and mispredict counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            mispred_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (redirect) mispred_q <= mispred_q + 32'd1;
        end
    end

    // BTB storage; updates proceed regardless of stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_type_q[i]   <= '0;
                btb_ctr_q[i]    <= '0;
            end
        end else if (btb_we) begin
            btb_valid_q[wr_idx]  <= 1'b1;
            btb_tag_q[wr_idx]    <= wr_tag;
            btb_target_q[wr_idx] <= wr_target;
            btb_type_q[wr_idx]   <= ex_npc_op;
            btb_ctr_q[wr_idx]    <= wr_ctr;
        end
    end

    assign pc          = pc_q;
    assign mispred_cnt = mispred_q;

endmodule
